// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
// Module      : lsu
// Description : Single-outstanding RV32I load/store unit with a req/gnt data bus.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_addr,
  input  logic [XLEN-1:0] in_wdata,
  input  logic            in_wen,
  input  logic [2:0]      in_funct3,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_rdata,
  output logic            out_err,
  output logic            bus_req,
  input  logic            bus_gnt,
  output logic            bus_we,
  output logic [XLEN-1:0] bus_addr,
  output logic [XLEN-1:0] bus_wdata,
  output logic [3:0]      bus_wstrb,
  input  logic            bus_rvalid,
  input  logic [XLEN-1:0] bus_rdata,
  input  logic            bus_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]      r_state;
  logic [1:0]      w_next;
  logic [1:0]      r_addr_lo;
  logic [2:0]      r_funct3;
  logic            r_wen;
  logic            r_bus_we;
  logic [XLEN-1:0] r_bus_addr;
  logic [XLEN-1:0] r_bus_wdata;
  logic [3:0]      r_bus_wstrb;
  logic [XLEN-1:0] r_rdata;
  logic            r_err;

  logic            w_accept;
  logic            w_f3_ok;
  logic            w_misaligned;
  logic            w_legal;
  logic [3:0]      w_wstrb;
  logic [XLEN-1:0] w_wdata;
  logic            w_capture;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [XLEN-1:0] w_load;

  assign w_accept = in_valid && (r_state == S_IDLE);

  // Decode legality of the op presented on the input port
  always_comb begin
    w_f3_ok = 1'b0;
    if (in_wen) begin
      w_f3_ok = (in_funct3 == 3'b000) || (in_funct3 == 3'b001) || (in_funct3 == 3'b010);
    end else begin
      w_f3_ok = (in_funct3 == 3'b000) || (in_funct3 == 3'b001) || (in_funct3 == 3'b010) ||
                (in_funct3 == 3'b100) || (in_funct3 == 3'b101);
    end
  end

  always_comb begin
    w_misaligned = 1'b0;
    case (in_funct3[1:0])
      2'b01:   w_misaligned = in_addr[0];
      2'b10:   w_misaligned = (in_addr[1:0] != 2'b00);
      default: w_misaligned = 1'b0;
    endcase
  end

  assign w_legal = w_f3_ok && !w_misaligned;

  always_comb begin
    w_wstrb = 4'b1111;
    w_wdata = in_wdata;
    case (in_funct3[1:0])
      2'b00: begin
        w_wstrb = 4'b0001 << in_addr[1:0];
        w_wdata = {4{in_wdata[7:0]}};
      end
      2'b01: begin
        w_wstrb = 4'b0011 << in_addr[1:0];
        w_wdata = {2{in_wdata[15:0]}};
      end
      default: begin
        w_wstrb = 4'b1111;
        w_wdata = in_wdata;
      end
    endcase
  end

  // Response is taken either on a combined grant+response or while waiting
  assign w_capture = ((r_state == S_REQ) && bus_gnt && bus_rvalid) ||
                     ((r_state == S_WAIT) && bus_rvalid);

  assign w_byte = 8'(bus_rdata >> {r_addr_lo, 3'b000});
  assign w_half = r_addr_lo[1] ? bus_rdata[31:16] : bus_rdata[15:0];

  always_comb begin
    w_load = bus_rdata;
    case (r_funct3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load = {24'd0, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b101:  w_load = {16'd0, w_half};
      default: w_load = bus_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_next = w_legal ? S_REQ : S_RESP;
        end
      end
      S_REQ: begin
        if (bus_gnt) begin
          w_next = bus_rvalid ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus_rvalid) begin
          w_next = S_RESP;
        end
      end
      S_RESP: begin
        if (out_ready) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    bus_req   = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      S_IDLE:  in_ready  = 1'b1;
      S_REQ:   bus_req   = 1'b1;
      S_RESP:  out_valid = 1'b1;
      default: begin
        in_ready  = 1'b0;
        bus_req   = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr_lo   <= 2'd0;
      r_funct3    <= 3'd0;
      r_wen       <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_bus_wstrb <= 4'd0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
    end else if (w_accept) begin
      r_addr_lo <= in_addr[1:0];
      r_funct3  <= in_funct3;
      r_wen     <= in_wen;
      r_rdata   <= '0;
      if (w_legal) begin
        r_bus_we    <= in_wen;
        r_bus_addr  <= {in_addr[XLEN-1:2], 2'b00};
        r_bus_wdata <= in_wen ? w_wdata : '0;
        r_bus_wstrb <= in_wen ? w_wstrb : 4'd0;
        r_err       <= 1'b0;
      end else begin
        // Rejected ops never reach the bus, so its outputs are parked at zero
        r_bus_we    <= 1'b0;
        r_bus_addr  <= '0;
        r_bus_wdata <= '0;
        r_bus_wstrb <= 4'd0;
        r_err       <= 1'b1;
      end
    end else if (w_capture) begin
      r_err   <= bus_err;
      r_rdata <= (bus_err || r_wen) ? '0 : w_load;
    end
  end

  assign bus_we    = r_bus_we;
  assign bus_addr  = r_bus_addr;
  assign bus_wdata = r_bus_wdata;
  assign bus_wstrb = r_bus_wstrb;
  assign out_rdata = r_rdata;
  assign out_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu
// Description : Directed plus randomized bench for lsu against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_addr = '0;
  logic [31:0] in_wdata = '0;
  logic        in_wen = 1'b0;
  logic [2:0]  in_funct3 = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_rdata;
  logic        out_err;
  logic        bus_req;
  logic        bus_gnt = 1'b0;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic        bus_err = 1'b0;

  int n_total = 0;
  int n_pass  = 0;

  lsu #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_wdata(in_wdata),
    .in_wen(in_wen), .in_funct3(in_funct3),
    .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata), .out_err(out_err),
    .bus_req(bus_req), .bus_gnt(bus_gnt), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb), .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        legal;
    logic [3:0]  strb;
    logic [31:0] bwdata;
    logic [31:0] rd;
  } exp_t;

  // Expected behaviour from access size in bytes and plain integer arithmetic
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] wd, input logic we,
                                 input logic [2:0] f3, input logic [31:0] rdw);
    exp_t   e;
    int     nb;
    longint v;
    longint lim;
    e.legal = 1'b0; e.strb = '0; e.bwdata = '0; e.rd = '0;
    if (we) e.legal = (f3 <= 3'd2);
    else    e.legal = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
    if (!e.legal) return e;
    nb = 1 << f3[1:0];
    if ((a % nb) != 0) begin
      e.legal = 1'b0;
      return e;
    end
    if (we) begin
      e.strb = 4'(((1 << nb) - 1) << (a % 4));
      case (nb)
        1:       e.bwdata = {4{wd[7:0]}};
        2:       e.bwdata = {2{wd[15:0]}};
        default: e.bwdata = wd;
      endcase
    end else begin
      v   = longint'(rdw) >> (8 * (a % 4));
      lim = longint'(1) << (8 * nb);
      v   = v % lim;
      if (!f3[2] && v >= lim / 2) v = v - lim;
      e.rd = v[31:0];
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] wd, input logic we,
                        input logic [2:0] f3, input logic [31:0] rdw, input logic berr,
                        input int gd, input int rd_dly, input int od);
    exp_t        e;
    logic [31:0] exp_rd;
    logic        exp_err;
    e = model(a, wd, we, f3, rdw);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_addr = a; in_wdata = wd; in_wen = we; in_funct3 = f3;
    step();
    in_valid = 1'b0; in_addr = $urandom; in_wdata = $urandom;
    in_wen = 1'($urandom); in_funct3 = 3'($urandom);
    if (!e.legal) begin
      chk("bad_no_req", 32'(bus_req), 32'd0);
      exp_rd = '0; exp_err = 1'b1;
    end else begin
      chk("req_up", 32'(bus_req), 32'd1);
      chk("bus_addr", bus_addr, {a[31:2], 2'b00});
      chk("bus_we", 32'(bus_we), 32'(we));
      chk("bus_wstrb", 32'(bus_wstrb), 32'(e.strb));
      if (we) chk("bus_wdata", bus_wdata, e.bwdata);
      for (int i = 0; i < gd; i++) begin
        step();
        chk("req_hold", 32'(bus_req), 32'd1);
        chk("addr_hold", bus_addr, {a[31:2], 2'b00});
        chk("strb_hold", 32'(bus_wstrb), 32'(e.strb));
      end
      bus_gnt = 1'b1;
      if (rd_dly == 0) begin
        bus_rvalid = 1'b1; bus_rdata = rdw; bus_err = berr;
      end
      step();
      bus_gnt = 1'b0; bus_rvalid = 1'b0;
      if (rd_dly > 0) begin
        chk("req_drop", 32'(bus_req), 32'd0);
        for (int i = 1; i < rd_dly; i++) begin
          step();
          chk("wait_no_out", 32'(out_valid), 32'd0);
        end
        bus_rvalid = 1'b1; bus_rdata = rdw; bus_err = berr;
        step();
        bus_rvalid = 1'b0;
      end
      exp_err = berr;
      exp_rd  = berr ? 32'd0 : e.rd;
    end
    chk("out_valid", 32'(out_valid), 32'd1);
    chk("out_rdata", out_rdata, exp_rd);
    chk("out_err", 32'(out_err), 32'(exp_err));
    for (int i = 0; i < od; i++) begin
      // Stray responses while a result is pending must not disturb it
      bus_rvalid = 1'b1; bus_rdata = $urandom; bus_err = 1'($urandom);
      step();
      bus_rvalid = 1'b0;
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_rdata", out_rdata, exp_rd);
      chk("hold_err", 32'(out_err), 32'(exp_err));
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("out_done", 32'(out_valid), 32'd0);
    chk("ready_again", 32'(in_ready), 32'd1);
    bus_err = 1'b0;
  endtask

  initial begin
    logic [2:0] f3;
    step(); step();
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_rdata", out_rdata, 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_bus_we", 32'(bus_we), 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_bus_wdata", bus_wdata, 32'd0);
    chk("rst_bus_wstrb", 32'(bus_wstrb), 32'd0);

    // LB, sign-extended byte from top lane, minimum latency
    run_op(32'h8000_0003, 32'h0, 1'b0, 3'b000, 32'h80FF_0000, 1'b0, 0, 0, 0);
    // SH to upper half
    run_op(32'h0000_0102, 32'h1234_ABCD, 1'b1, 3'b001, 32'hDEAD_BEEF, 1'b0, 0, 1, 0);
    // Misaligned LW and illegal funct3
    run_op(32'h0000_0101, 32'h0, 1'b0, 3'b010, 32'h0, 1'b0, 0, 0, 0);
    run_op(32'h0000_0100, 32'h0, 1'b0, 3'b011, 32'h0, 1'b0, 0, 0, 0);
    // Slow grant, slow response, backpressured writeback
    run_op(32'h0000_0204, 32'h0, 1'b0, 3'b010, 32'hCAFE_F00D, 1'b0, 5, 3, 4);
    // Bus error on LHU
    run_op(32'h0000_0002, 32'h0, 1'b0, 3'b101, 32'hBEEF_0000, 1'b1, 0, 1, 0);

    // Reset while waiting for the response
    in_valid = 1'b1; in_addr = 32'h40; in_wen = 1'b0; in_funct3 = 3'b010;
    step();
    in_valid = 1'b0;
    bus_gnt = 1'b1;
    step();
    bus_gnt = 1'b0;
    chk("wait_req_low", 32'(bus_req), 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("wrst_in_ready", 32'(in_ready), 32'd1);
    chk("wrst_out_valid", 32'(out_valid), 32'd0);
    chk("wrst_bus_addr", bus_addr, 32'd0);
    bus_rvalid = 1'b1; bus_rdata = 32'h1111_2222;
    step();
    bus_rvalid = 1'b0;
    chk("late_rvalid_ignored", 32'(out_valid), 32'd0);
    chk("late_in_ready", 32'(in_ready), 32'd1);

    // Reset while requesting
    in_valid = 1'b1; in_addr = 32'h80; in_wen = 1'b1; in_wdata = 32'h5; in_funct3 = 3'b010;
    step();
    in_valid = 1'b0;
    chk("req_before_rst", 32'(bus_req), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("req_rst_drop", 32'(bus_req), 32'd0);
    chk("req_rst_wstrb", 32'(bus_wstrb), 32'd0);

    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      a  = $urandom;
      f3 = 3'($urandom);
      if ($urandom_range(0, 3) != 0) a[1:0] = (f3[1:0] == 2'b10) ? 2'b00 :
                                              (f3[1:0] == 2'b01) ? {1'($urandom), 1'b0} : a[1:0];
      run_op(a, $urandom, 1'($urandom), f3, $urandom, ($urandom_range(0, 7) == 0),
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
